cv32e40p_rf_wb_arbiter: RTL and testbench
=========================================

# cv32e40p_rf_wb_arbiter

Write-back arbiter driving the two write ports of the flip-flop register file (integer plus FP, 6-bit address). It collects results from EX (single-cycle), LSU (loads) and APU (multi-cycle FP/accelerator) and presents them as registered write requests on ports A and B. It also keeps a pending-destination scoreboard for in-flight APU ops, which the decoder uses for hazard stalls.

## Interface
Parameters:
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank.
- DATA_WIDTH, 32, write data width.
- APU_FIFO_DEPTH, 2, APU result buffer entries (>=2).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  EX result valid; always accepted, no ready.
- ex_waddr_i  in  ADDR_WIDTH  EX destination.
- ex_wdata_i  in  DATA_WIDTH  EX result.
- lsu_valid_i  in  1  load result valid.
- lsu_ready_o  out  1  load result accepted when high with valid.
- lsu_waddr_i  in  ADDR_WIDTH  load destination.
- lsu_wdata_i  in  DATA_WIDTH  load data.
- apu_issue_i  in  1  APU op issued; marks destination pending.
- apu_issue_waddr_i  in  ADDR_WIDTH  destination of the issued op.
- apu_valid_i  in  1  APU result valid.
- apu_ready_o  out  1  APU result accepted when high with valid.
- apu_waddr_i  in  ADDR_WIDTH  APU result destination.
- apu_wdata_i  in  DATA_WIDTH  APU result.
- waddr_a_o, wdata_a_o, we_a_o  out  ADDR_WIDTH/DATA_WIDTH/1  register file port A (LSU/APU).
- waddr_b_o, wdata_b_o, we_b_o  out  ADDR_WIDTH/DATA_WIDTH/1  register file port B (EX).
- pending_o  out  2**ADDR_WIDTH  per-register APU pending bits.
- busy_o  out  1  FIFO non-empty or any pending bit set.

## Operation
- Port B: registered copy of the EX request. we_b_o = ex_valid_i && ex_waddr_i != 0.
- Port A source selection each cycle: LSU if lsu_valid_i && lsu_ready_o. Otherwise the FIFO head if the FIFO is non-empty. Otherwise none (we_a_o = 0).
- APU results are always pushed into the FIFO; there is no bypass. apu_ready_o = (count != APU_FIFO_DEPTH), computed from registered count only. A push and pop in the same cycle while full is not possible, because ready is low.
- FIFO: read/write pointers wrap modulo APU_FIFO_DEPTH. count is $clog2(APU_FIFO_DEPTH+1) bits. Simultaneous push+pop leaves count unchanged.
- Starvation guard: lsu_streak counts consecutive cycles in which the LSU wrote port A while the FIFO was non-empty, saturating at STARVE_LIMIT (3).
  - On reaching the limit, a registered flag forces lsu_ready_o = 0 for exactly the next cycle; the FIFO head drains in that cycle and the streak clears.
  - The streak clears whenever the FIFO is empty.
- Writes to address 0 complete their handshake but assert no write enable. They do not affect pending bits.
- Scoreboard:
  - apu_issue_i sets pending[apu_issue_waddr_i] (address 0 is ignored).
  - Loading an APU entry into the port-A register clears pending[that address].
  - A set and a clear to the same address in the same cycle leave the bit set.
  - Issuing to an already-pending address is illegal and is flagged by an assertion.
- Same-address collisions between A and B are passed through unchanged. The register file gives port B precedence, and in-order issue upstream guarantees that is correct.

## Timing
- Reset values: we_a_o = we_b_o = 0, all addr/data outputs 0, pending_o = 0, busy_o = 0, lsu_ready_o = 1, apu_ready_o = 1, FIFO empty, streak 0.
- EX latency: request in cycle N -> port B write in cycle N+1.
- LSU latency: accepted in cycle N -> port A write in cycle N+1.
- APU latency: accepted in cycle N -> earliest port A write in cycle N+2. It is delayed further by each cycle the LSU wins.
- pending_o updates one cycle after apu_issue_i. The clear is visible in the same cycle as the corresponding we_a_o.
- Reset asserted mid-operation: FIFO contents and pending bits are discarded immediately (asynchronous). No write enable is asserted until two edges after deassertion.

## Structure
- cv32e40p_pkg holds:
  - typedef enum wb_src_e {WB_NONE, WB_LSU, WB_APU};
  - localparam STARVE_LIMIT = 3.
- Sub-module cv32e40p_wb_fifo: parameterised depth/width FIFO with push/pop/full/empty/count. It is instantiated once for APU results.
- The arbiter, streak counter, scoreboard and output registers live in the top module.

## Test plan
- Reset: hold rst_n low with all valids high -> every we 0, pending 0, both readies 1. After release, the first writes appear no earlier than the second edge.
- EX write x5=0xDEADBEEF in cycle 0 -> cycle 1: we_b_o=1, waddr_b_o=5, wdata_b_o=0xDEADBEEF. An EX write to x0 -> we_b_o stays 0.
- APU op:
  - apu_issue to f3 (addr 35) -> pending_o[35]=1 next cycle.
  - Result 0x3F800000 accepted in cycle 4 -> we_a_o with addr 35 in cycle 6, pending_o[35]=0 in cycle 6.
- FIFO full: three back-to-back APU results with LSU continuously valid -> apu_ready_o=0 after 2 accepts. After 3 LSU wins, lsu_ready_o=0 for one cycle and the APU head is written; order is preserved.
- Simultaneous: ex and lsu both target x7 in the same cycle -> we_a_o and we_b_o both 1 next cycle with addr 7.
- Mid-flight reset: FIFO holding 2 entries with pending bits set, then rst_n pulsed low -> all cleared. No stale write appears afterwards.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types and constants for the register-file write-back path
package cv32e40p_pkg;
  typedef enum logic [1:0] {WB_NONE, WB_LSU, WB_APU} wb_src_e;
  localparam int STARVE_LIMIT = 3;
endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// cv32e40p_wb_fifo: circular buffer with occupancy count, pointers wrap modulo DEPTH
module cv32e40p_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q == PW'(DEPTH-1) ? '0 : wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q == PW'(DEPTH-1) ? '0 : rptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  // storage is data-only, so it needs no reset
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end
  assign data_o  = mem_q[rptr_q];
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// cv32e40p_rf_wb_arbiter: merges EX, LSU and APU results onto the two register-file
// write ports and tracks destinations of in-flight APU ops.
module cv32e40p_rf_wb_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int APU_FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid_i,
  input  logic [ADDR_WIDTH-1:0]    ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]    ex_wdata_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
  input  logic                     apu_issue_i,
  input  logic [ADDR_WIDTH-1:0]    apu_issue_waddr_i,
  input  logic                     apu_valid_i,
  output logic                     apu_ready_o,
  input  logic [ADDR_WIDTH-1:0]    apu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    apu_wdata_i,
  output logic [ADDR_WIDTH-1:0]    waddr_a_o,
  output logic [DATA_WIDTH-1:0]    wdata_a_o,
  output logic                     we_a_o,
  output logic [ADDR_WIDTH-1:0]    waddr_b_o,
  output logic [DATA_WIDTH-1:0]    wdata_b_o,
  output logic                     we_b_o,
  output logic [2**ADDR_WIDTH-1:0] pending_o,
  output logic                     busy_o
);
  localparam int NREG = 2**ADDR_WIDTH;
  localparam int SW   = $clog2(STARVE_LIMIT+1);
  localparam int CW   = $clog2(APU_FIFO_DEPTH+1);
  wb_src_e               src;
  logic                  push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [ADDR_WIDTH-1:0] head_waddr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  starve_q, starve_d;
  logic [NREG-1:0]       pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q;
  logic                  we_a_q, we_a_d, we_b_q;

  assign lsu_ready_o = !starve_q;
  assign apu_ready_o = !fifo_full;
  assign push        = apu_valid_i && apu_ready_o;
  assign pop         = src == WB_APU;

  cv32e40p_wb_fifo #(
    .DEPTH(APU_FIFO_DEPTH),
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_apu_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i ({apu_waddr_i, apu_wdata_i}),
    .pop_i  (pop),
    .data_o ({head_waddr, head_wdata}),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    src       = (lsu_valid_i && lsu_ready_o) ? WB_LSU : fifo_empty ? WB_NONE : WB_APU;
    waddr_a_d = src == WB_LSU ? lsu_waddr_i : src == WB_APU ? head_waddr : waddr_a_q;
    wdata_a_d = src == WB_LSU ? lsu_wdata_i : src == WB_APU ? head_wdata : wdata_a_q;
    we_a_d    = src != WB_NONE && waddr_a_d != '0;
    // only LSU wins that hold back a waiting APU result count towards starvation
    streak_d  = (fifo_empty || src != WB_LSU) ? '0 :
                streak_q == SW'(STARVE_LIMIT) ? streak_q : streak_q + 1'b1;
    starve_d  = streak_d == SW'(STARVE_LIMIT);
    pending_d = pending_q;
    if (pop && head_waddr != '0) pending_d[head_waddr] = 1'b0;
    if (apu_issue_i && apu_issue_waddr_i != '0) pending_d[apu_issue_waddr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q  <= '0;
      starve_q  <= 1'b0;
      pending_q <= '0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_a_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      we_b_q    <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      we_a_q    <= we_a_d;
      waddr_b_q <= ex_waddr_i;
      wdata_b_q <= ex_wdata_i;
      we_b_q    <= ex_valid_i && ex_waddr_i != '0;
    end
  end

  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_a_o    = we_a_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;
  assign we_b_o    = we_b_q;
  assign pending_o = pending_q;
  assign busy_o    = fifo_count != '0 || |pending_q;

  // a re-issue is only legal when the previous result retires in the same cycle
  assert property (@(posedge clk) disable iff (!rst_n)
    apu_issue_i && apu_issue_waddr_i != '0 |->
      !pending_q[apu_issue_waddr_i] || (pop && head_waddr == apu_issue_waddr_i));
endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// tb_cv32e40p_rf_wb_arbiter: scenario tasks push expected port writes into queues;
// a negedge monitor pops and compares them as the write enables appear.
module tb_cv32e40p_rf_wb_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid_i, lsu_valid_i, apu_issue_i, apu_valid_i;
  logic [5:0]  ex_waddr_i, lsu_waddr_i, apu_issue_waddr_i, apu_waddr_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i, apu_wdata_i;
  logic        lsu_ready_o, apu_ready_o, we_a_o, we_b_o, busy_o;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic [63:0] pending_o;

  typedef struct packed {logic [5:0] a; logic [31:0] d;} wr_t;
  wr_t qa[$], qb[$];
  wr_t ea, eb;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  cv32e40p_rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .apu_issue_i(apu_issue_i), .apu_issue_waddr_i(apu_issue_waddr_i),
    .apu_valid_i(apu_valid_i), .apu_ready_o(apu_ready_o),
    .apu_waddr_i(apu_waddr_i), .apu_wdata_i(apu_wdata_i),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
    .pending_o(pending_o), .busy_o(busy_o)
  );

  always @(negedge clk) begin
    if (rst_n && we_a_o) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL port_a_write: got addr %0d data %h, required no write", waddr_a_o, wdata_a_o);
      end else begin
        ea = qa.pop_front();
        if ({waddr_a_o, wdata_a_o} !== ea) begin
          n_bad++;
          $display("FAIL port_a_write: got addr %0d data %h, required addr %0d data %h", waddr_a_o, wdata_a_o, ea.a, ea.d);
        end
      end
    end
    if (rst_n && we_b_o) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL port_b_write: got addr %0d data %h, required no write", waddr_b_o, wdata_b_o);
      end else begin
        eb = qb.pop_front();
        if ({waddr_b_o, wdata_b_o} !== eb) begin
          n_bad++;
          $display("FAIL port_b_write: got addr %0d data %h, required addr %0d data %h", waddr_b_o, wdata_b_o, eb.a, eb.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    apu_issue_i = 0; apu_issue_waddr_i = 0;
    apu_valid_i = 0; apu_waddr_i = 0; apu_wdata_i = 0;
  endtask

  task automatic test_reset;
    ex_valid_i = 1; ex_waddr_i = 3; ex_wdata_i = 32'h1111;
    lsu_valid_i = 1; lsu_waddr_i = 4; lsu_wdata_i = 32'h2222;
    apu_valid_i = 1; apu_waddr_i = 5; apu_wdata_i = 32'h3333;
    apu_issue_i = 1; apu_issue_waddr_i = 9;
    repeat (3) tick;
    n_vec++;
    if ({we_a_o, we_b_o, busy_o, lsu_ready_o, apu_ready_o} !== 5'b00011) begin
      n_bad++;
      $display("FAIL reset_ctrl: got we_a/we_b/busy/lrdy/ardy %b, required 00011", {we_a_o, we_b_o, busy_o, lsu_ready_o, apu_ready_o});
    end
    n_vec++;
    if (pending_o !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_pending: got %h, required 0", pending_o);
    end
    @(negedge clk);
    idle;
    rst_n = 1;
    #1;
    n_vec++;
    if ({we_a_o, we_b_o, waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o} !== '0) begin
      n_bad++;
      $display("FAIL release_outputs: got we_a %b we_b %b, required all outputs 0", we_a_o, we_b_o);
    end
    tick; tick;
    n_vec++;
    if ({we_a_o, we_b_o, busy_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL release_idle: got we_a/we_b/busy %b, required 000", {we_a_o, we_b_o, busy_o});
    end
  endtask

  task automatic test_ex;
    ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEADBEEF;
    qb.push_back({6'd5, 32'hDEADBEEF});
    tick;
    n_vec++;
    if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL ex_latency: got we %b addr %0d data %h, required we 1 addr 5 data deadbeef", we_b_o, waddr_b_o, wdata_b_o);
    end
    ex_waddr_i = 0; ex_wdata_i = 32'hCAFE;
    tick;
    n_vec++;
    if (we_b_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ex_x0: got we_b %b, required 0", we_b_o);
    end
    for (int i = 0; i < 4; i++) begin
      ex_waddr_i = 6'($urandom_range(1, 63));
      ex_wdata_i = $urandom;
      qb.push_back({ex_waddr_i, ex_wdata_i});
      tick;
    end
    idle;
    tick; tick;
    n_vec++;
    if (qb.size() != 0) begin
      n_bad++;
      $display("FAIL ex_drain: got %0d writes outstanding, required 0", qb.size());
    end
  endtask

  task automatic test_apu;
    apu_issue_i = 1; apu_issue_waddr_i = 35;
    tick;
    idle;
    n_vec++;
    if ({pending_o[35], busy_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL apu_pending_set: got pending %b busy %b, required 1 1", pending_o[35], busy_o);
    end
    tick; tick;
    apu_valid_i = 1; apu_waddr_i = 35; apu_wdata_i = 32'h3F800000;
    qa.push_back({6'd35, 32'h3F800000});
    n_vec++;
    if (apu_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL apu_ready_idle: got %b, required 1", apu_ready_o);
    end
    tick;
    idle;
    n_vec++;
    if ({we_a_o, pending_o[35]} !== 2'b01) begin
      n_bad++;
      $display("FAIL apu_n1: got we_a %b pending %b, required 0 1", we_a_o, pending_o[35]);
    end
    tick;
    n_vec++;
    if ({we_a_o, waddr_a_o, pending_o[35]} !== {1'b1, 6'd35, 1'b0}) begin
      n_bad++;
      $display("FAIL apu_n2: got we_a %b addr %0d pending %b, required 1 35 0", we_a_o, waddr_a_o, pending_o[35]);
    end
    tick;
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL apu_busy_clear: got %b, required 0", busy_o);
    end
  endtask

  task automatic test_fifo_full;
    logic [13:0] ar_exp = 14'b11111000100011;
    logic [13:0] lr_exp = 14'b10111011101111;
    int li = 0, ai = 0;
    logic acc_l, acc_a;
    for (int k = 0; k < 3; k++) begin
      apu_issue_i = 1; apu_issue_waddr_i = 6'(40 + k);
      tick;
    end
    idle;
    for (int k = 0; k < 4; k++) qa.push_back({6'(10 + k), 32'h1000_0000 + 32'(k)});
    qa.push_back({6'd40, 32'hA000_0000});
    for (int k = 4; k < 7; k++) qa.push_back({6'(10 + k), 32'h1000_0000 + 32'(k)});
    qa.push_back({6'd41, 32'hA000_0001});
    for (int k = 7; k < 10; k++) qa.push_back({6'(10 + k), 32'h1000_0000 + 32'(k)});
    qa.push_back({6'd42, 32'hA000_0002});
    for (int c = 0; c < 14; c++) begin
      lsu_valid_i = li < 10; lsu_waddr_i = 6'(10 + li); lsu_wdata_i = 32'h1000_0000 + 32'(li);
      apu_valid_i = ai < 3; apu_waddr_i = 6'(40 + ai); apu_wdata_i = 32'hA000_0000 + 32'(ai);
      n_vec += 2;
      if (apu_ready_o !== ar_exp[c]) begin
        n_bad++;
        $display("FAIL full_apu_ready c%0d: got %b, required %b", c, apu_ready_o, ar_exp[c]);
      end
      if (lsu_ready_o !== lr_exp[c]) begin
        n_bad++;
        $display("FAIL starve_lsu_ready c%0d: got %b, required %b", c, lsu_ready_o, lr_exp[c]);
      end
      if (c == 5 || c == 9) begin
        n_vec++;
        if (pending_o[42:40] !== (c == 5 ? 3'b110 : 3'b100)) begin
          n_bad++;
          $display("FAIL full_pending c%0d: got %b, required %b", c, pending_o[42:40], c == 5 ? 3'b110 : 3'b100);
        end
      end
      acc_l = lsu_valid_i && lsu_ready_o;
      acc_a = apu_valid_i && apu_ready_o;
      tick;
      li += int'(acc_l);
      ai += int'(acc_a);
    end
    idle;
    tick;
    n_vec++;
    if (li != 10 || ai != 3 || qa.size() != 0 || pending_o !== 64'd0) begin
      n_bad++;
      $display("FAIL full_drain: got lsu %0d apu %0d outstanding %0d pending %h, required 10 3 0 0", li, ai, qa.size(), pending_o);
    end
  endtask

  task automatic test_simultaneous;
    ex_valid_i = 1; ex_waddr_i = 7; ex_wdata_i = 32'hB0B0;
    lsu_valid_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 32'hA0A0;
    qa.push_back({6'd7, 32'hA0A0});
    qb.push_back({6'd7, 32'hB0B0});
    tick;
    n_vec++;
    if ({we_a_o, we_b_o, waddr_a_o, waddr_b_o} !== {2'b11, 6'd7, 6'd7}) begin
      n_bad++;
      $display("FAIL collide_x7: got we %b%b addr %0d/%0d, required 11 7/7", we_a_o, we_b_o, waddr_a_o, waddr_b_o);
    end
    ex_waddr_i = 0; lsu_waddr_i = 0;
    tick;
    idle;
    n_vec++;
    if ({we_a_o, we_b_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL both_x0: got we %b%b, required 00", we_a_o, we_b_o);
    end
    tick;
  endtask

  task automatic test_set_clear;
    apu_valid_i = 1; apu_waddr_i = 50; apu_wdata_i = 32'h5A5A;
    qa.push_back({6'd50, 32'h5A5A});
    tick;
    idle;
    apu_issue_i = 1; apu_issue_waddr_i = 50;
    tick;
    idle;
    n_vec++;
    if ({we_a_o, waddr_a_o, pending_o[50]} !== {1'b1, 6'd50, 1'b1}) begin
      n_bad++;
      $display("FAIL set_wins: got we_a %b addr %0d pending %b, required 1 50 1", we_a_o, waddr_a_o, pending_o[50]);
    end
    apu_valid_i = 1; apu_waddr_i = 50; apu_wdata_i = 32'h1234;
    qa.push_back({6'd50, 32'h1234});
    tick;
    idle;
    tick;
    n_vec++;
    if ({we_a_o, pending_o[50]} !== 2'b10) begin
      n_bad++;
      $display("FAIL clear_50: got we_a %b pending %b, required 1 0", we_a_o, pending_o[50]);
    end
    apu_valid_i = 1; apu_waddr_i = 0; apu_wdata_i = 32'hFFFF;
    tick;
    idle;
    tick;
    n_vec++;
    if ({we_a_o, busy_o, pending_o[0]} !== 3'b000) begin
      n_bad++;
      $display("FAIL apu_x0: got we_a %b busy %b pending0 %b, required 000", we_a_o, busy_o, pending_o[0]);
    end
  endtask

  task automatic test_midflight_reset;
    apu_issue_i = 1; apu_issue_waddr_i = 44; tick;
    apu_issue_waddr_i = 45; tick;
    idle;
    lsu_valid_i = 1; lsu_waddr_i = 20; lsu_wdata_i = 32'h2020;
    apu_valid_i = 1; apu_waddr_i = 44; apu_wdata_i = 32'h4444;
    qa.push_back({6'd20, 32'h2020});
    tick;
    lsu_waddr_i = 21; lsu_wdata_i = 32'h2121;
    apu_waddr_i = 45; apu_wdata_i = 32'h4545;
    qa.push_back({6'd21, 32'h2121});
    tick;
    apu_valid_i = 0; lsu_waddr_i = 22; lsu_wdata_i = 32'h2222;
    n_vec++;
    if ({apu_ready_o, busy_o, pending_o[45:44]} !== 4'b0111) begin
      n_bad++;
      $display("FAIL pre_reset: got ardy %b busy %b pending %b, required 0 1 11", apu_ready_o, busy_o, pending_o[45:44]);
    end
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    n_vec++;
    if ({apu_ready_o, lsu_ready_o, busy_o, we_a_o} !== 4'b1100 || pending_o !== 64'd0) begin
      n_bad++;
      $display("FAIL async_clear: got ardy/lrdy/busy/we_a %b pending %h, required 1100 0", {apu_ready_o, lsu_ready_o, busy_o, we_a_o}, pending_o);
    end
    idle;
    tick; tick;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_vec++;
      if ({we_a_o, we_b_o, busy_o} !== 3'b000) begin
        n_bad++;
        $display("FAIL stale_write %0d: got we_a/we_b/busy %b, required 000", i, {we_a_o, we_b_o, busy_o});
      end
    end
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL reset_drain: got %0d/%0d outstanding, required 0/0", qa.size(), qb.size());
    end
  endtask

  initial begin
    idle;
    test_reset;
    test_ex;
    test_apu;
    test_fifo_full;
    test_simultaneous;
    test_set_clear;
    test_midflight_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
